// File: rtl/float_seq.sv
// float_seq: control sequencer for the floating-point datapath.
//   Accepts one packed float instruction on a valid/ready handshake. It holds
//   the ALU controls for EXEC_CYCLES cycles, then spends one cycle in
//   write-back (FW_En pulse, status latch). The next cycle is a Done pulse,
//   and after that the block is ready again. Loads skip the execute phase.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   I_Valid/I_Ready   instruction handshake
//   Instr[21:0]       {op[4:0], dest[4:0], R[4:0], S[4:0], imm_S, load}
//   FP_Op, FR_Addr, FS_Addr, FW_Addr, FW_En, F_Sel, FS_Sel   datapath controls
//   FP_Status         ALU status flags in
//   Status_Out        status latched at write-back
//   Done, Exc         completion pulse, exception flag
// Optional: define FLOAT_SEQ_EXC_SUPPRESS_EN to suppress write-back when
//   FP_Status[5] is set on an ALU op, and to report it on Exc.
module float_seq #(
  parameter int EXEC_CYCLES = 2,
  parameter int OP_W        = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            I_Valid,
  output logic            I_Ready,
  input  logic [21:0]     Instr,
  output logic [OP_W-1:0] FP_Op,
  output logic [4:0]      FR_Addr,
  output logic [4:0]      FS_Addr,
  output logic [4:0]      FW_Addr,
  output logic            FW_En,
  output logic            F_Sel,
  output logic            FS_Sel,
  input  logic [5:0]      FP_Status,
  output logic [5:0]      Status_Out,
  output logic            Done,
  output logic            Exc
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_DONE} state_t;

  state_t     r_state, w_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_accept;
  logic       w_supp;
`ifdef FLOAT_SEQ_EXC_SUPPRESS_EN
  logic       r_supp;
`endif

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_accept  = (r_state == S_IDLE) && I_Valid && I_Ready;
    w_supp    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (Instr[0]) begin
            w_nxt = S_WB;
          end else begin
            w_nxt     = S_EXEC;
            w_cnt_nxt = 4'(EXEC_CYCLES - 1);
          end
        end
      end
      S_EXEC: begin
        if (r_cnt == 4'd0) w_nxt = S_WB;
        else               w_cnt_nxt = r_cnt - 4'd1;
      end
      S_WB:    w_nxt = S_DONE;
      default: w_nxt = S_IDLE;
    endcase
`ifdef FLOAT_SEQ_EXC_SUPPRESS_EN
    // FW_En is registered, so the suppress decision is taken on the edge
    // entering WB. Only ALU ops pass through EXEC, so loads are never
    // suppressed.
    w_supp = (r_state == S_EXEC) && (w_nxt == S_WB) && FP_Status[5];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      I_Ready    <= 1'b0;
      FW_En      <= 1'b0;
      Done       <= 1'b0;
      Exc        <= 1'b0;
      F_Sel      <= 1'b0;
      FS_Sel     <= 1'b0;
      FP_Op      <= '0;
      FR_Addr    <= 5'd0;
      FS_Addr    <= 5'd0;
      FW_Addr    <= 5'd0;
      Status_Out <= 6'd0;
`ifdef FLOAT_SEQ_EXC_SUPPRESS_EN
      r_supp     <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      I_Ready <= (w_nxt == S_IDLE);
      FW_En   <= (w_nxt == S_WB) && !w_supp;
      Done    <= (w_nxt == S_DONE);
      if (w_accept) begin
        FP_Op   <= OP_W'(Instr[21:17]);
        FW_Addr <= Instr[16:12];
        FR_Addr <= Instr[11:7];
        FS_Addr <= Instr[6:2];
        FS_Sel  <= Instr[1];
        F_Sel   <= Instr[0];
        Exc     <= 1'b0;
      end
      // F_Sel still holds the load flag of the instruction in flight.
      if (r_state == S_WB && !F_Sel) Status_Out <= FP_Status;
`ifdef FLOAT_SEQ_EXC_SUPPRESS_EN
      if (w_nxt == S_WB) r_supp <= w_supp;
      if (r_state == S_WB) Exc <= r_supp;
`endif
    end
  end

endmodule

// File: tb/tb_float_seq.sv
module tb_float_seq;
  localparam int E = 2;
`ifdef FLOAT_SEQ_EXC_SUPPRESS_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, I_Valid, I_Ready;
  logic [21:0] Instr;
  logic [4:0]  FP_Op, FR_Addr, FS_Addr, FW_Addr;
  logic        FW_En, F_Sel, FS_Sel, Done, Exc;
  logic [5:0]  FP_Status, Status_Out;

  float_seq #(.EXEC_CYCLES(E), .OP_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .I_Valid(I_Valid), .I_Ready(I_Ready),
    .Instr(Instr), .FP_Op(FP_Op), .FR_Addr(FR_Addr), .FS_Addr(FS_Addr),
    .FW_Addr(FW_Addr), .FW_En(FW_En), .F_Sel(F_Sel), .FS_Sel(FS_Sel),
    .FP_Status(FP_Status), .Status_Out(Status_Out), .Done(Done), .Exc(Exc)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int n_fw = 0, n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: k counts cycles since the accepting edge; an instruction
  // occupies L cycles (write-back in cycle L-1, Done in cycle L).
  int k = 0, L = 0;
  bit m_on = 0;
  logic       e_rdy, e_fwen, e_done, e_fsel, e_fssel, e_exc;
  logic [4:0] e_op, e_fr, e_fs, e_fw;
  logic [5:0] e_stat;

  always @(posedge clk) begin
    if (!reset_n) begin
      k = 0; L = 0; m_on = 1;
      e_rdy = 0; e_fwen = 0; e_done = 0; e_fsel = 0; e_fssel = 0; e_exc = 0;
      e_op = 0; e_fr = 0; e_fs = 0; e_fw = 0; e_stat = 0;
    end else begin
      if (k == 0) begin
        if (I_Valid && e_rdy) begin
          e_op = Instr[21:17]; e_fw = Instr[16:12]; e_fr = Instr[11:7];
          e_fs = Instr[6:2]; e_fssel = Instr[1]; e_fsel = Instr[0];
          L = Instr[0] ? 2 : E + 2;
          k = 1; e_exc = 0;
        end
      end else if (k == L) begin
        k = 0;
      end else begin
        if (k == L - 1 && !e_fsel) begin
          e_stat = FP_Status;
          e_exc  = EXC_ON && FP_Status[5];
        end
        k = k + 1;
      end
      e_rdy  = (k == 0);
      e_fwen = (k != 0) && (k == L - 1) && !(EXC_ON && !e_fsel && FP_Status[5]);
      e_done = (k != 0) && (k == L);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("I_Ready", 32'(I_Ready), 32'(e_rdy));
      chk("FW_En", 32'(FW_En), 32'(e_fwen));
      chk("Done", 32'(Done), 32'(e_done));
      chk("Exc", 32'(Exc), 32'(e_exc));
      chk("FP_Op", 32'(FP_Op), 32'(e_op));
      chk("FR_Addr", 32'(FR_Addr), 32'(e_fr));
      chk("FS_Addr", 32'(FS_Addr), 32'(e_fs));
      chk("FW_Addr", 32'(FW_Addr), 32'(e_fw));
      chk("F_Sel", 32'(F_Sel), 32'(e_fsel));
      chk("FS_Sel", 32'(FS_Sel), 32'(e_fssel));
      chk("Status_Out", 32'(Status_Out), 32'(e_stat));
      if (FW_En === 1'b1) n_fw++;
      if (Done === 1'b1) n_done++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present an instruction and return #1 after the accepting edge (cycle 1).
  task automatic send(input logic [21:0] ins, input logic [5:0] st);
    int n = 0;
    Instr = ins; FP_Status = st; I_Valid = 1'b1;
    while (I_Ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) chk("accept_timeout", 32'(I_Ready), 32'd1);
    @(posedge clk); #1;
    I_Valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 0; I_Valid = 0; Instr = '0; FP_Status = '0;
    cyc(2);
    chk("rst_ready", 32'(I_Ready), 32'd0);
    chk("rst_outs", {FP_Op, FR_Addr, FS_Addr, FW_Addr, FW_En, F_Sel, FS_Sel, Done, Exc},
        32'd0);
    chk("rst_status", 32'(Status_Out), 32'd0);
    reset_n = 1;
    cyc(1);
    chk("ready_after_rst", 32'(I_Ready), 32'd1);

    // ALU op: op=3 dest=7 R=1 S=2
    send({5'h03, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0}, 6'h15);
    chk("alu_op_c1", 32'(FP_Op), 32'd3);
    chk("alu_fr_c1", 32'(FR_Addr), 32'd1);
    chk("alu_fs_c1", 32'(FS_Addr), 32'd2);
    chk("alu_fwen_c1", 32'(FW_En), 32'd0);
    cyc(1);
    chk("alu_op_c2", 32'(FP_Op), 32'd3);
    cyc(1);
    chk("alu_fwen_c3", 32'(FW_En), 32'd1);
    chk("alu_fw_c3", 32'(FW_Addr), 32'd7);
    cyc(1);
    chk("alu_done_c4", 32'(Done), 32'd1);
    chk("alu_stat_c4", 32'(Status_Out), 32'h15);
    cyc(1);

    // Load: dest=9
    send({5'h00, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1}, 6'h2A);
    chk("ld_fwen_c1", 32'(FW_En), 32'd1);
    chk("ld_fsel_c1", 32'(F_Sel), 32'd1);
    chk("ld_fw_c1", 32'(FW_Addr), 32'd9);
    cyc(1);
    chk("ld_done_c2", 32'(Done), 32'd1);
    chk("ld_stat_kept", 32'(Status_Out), 32'h15);
    cyc(1);

    // Immediate S with I_Valid pulses while busy
    n_fw = 0;
    send({5'h02, 5'd5, 5'd3, 5'd4, 1'b1, 1'b0}, 6'h07);
    Instr = {5'h09, 5'd10, 5'd11, 5'd12, 1'b0, 1'b0}; I_Valid = 1;
    chk("imm_fssel_c1", 32'(FS_Sel), 32'd1);
    chk("imm_fr_c1", 32'(FR_Addr), 32'd3);
    cyc(1); I_Valid = 0;
    chk("imm_fssel_c2", 32'(FS_Sel), 32'd1);
    cyc(1); I_Valid = 1;
    chk("imm_fssel_wb", 32'(FS_Sel), 32'd1);
    chk("imm_fwen_wb", 32'(FW_En), 32'd1);
    cyc(1); I_Valid = 0;
    chk("imm_done", 32'(Done), 32'd1);
    cyc(2);
    chk("imm_one_write", 32'(n_fw), 32'd1);
    chk("imm_op_held", 32'(FP_Op), 32'd2);

    // Reset in the first EXEC cycle
    send({5'h04, 5'd6, 5'd1, 5'd1, 1'b0, 1'b0}, 6'h00);
    n_fw = 0; n_done = 0;
    reset_n = 0;
    cyc(1);
    chk("mid_rst_fwen", 32'(FW_En), 32'd0);
    reset_n = 1;
    cyc(1);
    chk("mid_rst_ready", 32'(I_Ready), 32'd1);
    cyc(4);
    chk("mid_rst_nowrite", 32'(n_fw), 32'd0);
    chk("mid_rst_nodone", 32'(n_done), 32'd0);

    // Invalid/overflow status on an ALU op
    n_fw = 0;
    send({5'h01, 5'd4, 5'd2, 5'd3, 1'b0, 1'b0}, 6'h20);
    cyc(3);
    chk("exc_done", 32'(Done), 32'd1);
    chk("exc_flag", 32'(Exc), 32'(EXC_ON));
    chk("exc_stat", 32'(Status_Out), 32'h20);
    cyc(1);
    chk("exc_writes", 32'(n_fw), EXC_ON ? 32'd0 : 32'd1);

    // All-zero / aliased addresses; Exc clears on accept
    send({5'h1f, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0}, 6'h01);
    chk("alias_exc_clr", 32'(Exc), 32'd0);
    chk("alias_op", 32'(FP_Op), 32'h1f);
    cyc(3);
    chk("alias_done", 32'(Done), 32'd1);
    chk("alias_stat", 32'(Status_Out), 32'h01);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
